// File: rtl/riscv_run_ctrl_if.sv
// Bus between the run controller and the surrounding top level / core:
// launch strobe, core observation inputs and the run result outputs.
interface riscv_run_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  dmem_wr;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wr_data;
    logic                  core_res_n;
    logic                  running;
    logic                  done;
    logic                  pass;
    logic [1:0]            cause;
    logic [30:0]           exit_code;
    logic [CNT_WIDTH-1:0]  cycle_count;

    modport master (
        output start, pc, instr, dmem_wr, dmem_addr, dmem_wr_data,
        input  core_res_n, running, done, pass, cause, exit_code, cycle_count
    );

    modport slave (
        input  start, pc, instr, dmem_wr, dmem_addr, dmem_wr_data,
        output core_res_n, running, done, pass, cause, exit_code, cycle_count
    );
endinterface

// File: rtl/riscv_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles and detects the end
// of a program (tohost store, ECALL, pc self-loop or cycle-budget timeout).
module riscv_run_ctrl #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          CNT_WIDTH    = 16,
    parameter int          RES_CYCLES   = 2,
    parameter int          MAX_CYCLES   = 32'h0000_0070,
    parameter int          STALL_CYCLES = 4,
    parameter int unsigned TOHOST_ADDR  = 32'h0000_00FC
) (
    input logic             clk,
    input logic             res,
    riscv_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int RW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES) : 1;
    localparam int SW = $clog2(STALL_CYCLES + 1);

    localparam logic [RW-1:0]         RES_LAST   = RW'(RES_CYCLES - 1);
    localparam logic [RW-1:0]         RES_ONE    = RW'(1);
    localparam logic [SW-1:0]         STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0]         STALL_ONE  = SW'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_SAT    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_AT = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] TOHOST_A   = ADDR_WIDTH'(TOHOST_ADDR);
    localparam logic [31:0]           ECALL_INSN = 32'h0000_0073;

    state_e                state_q, state_d;
    logic [RW-1:0]         rcnt_q, rcnt_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                  core_res_n_q, core_res_n_d;
    logic                  running_q, running_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [1:0]            cause_q, cause_d;
    logic [30:0]           exit_code_q, exit_code_d;
    logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;

    logic tohost_s, ecall_s, same_pc_s, halt_s, timeout_s;

    // Next-state and next-output logic; core inputs are only looked at in RUN.
    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        stall_d       = stall_q;
        last_pc_d     = last_pc_q;
        core_res_n_d  = core_res_n_q;
        running_d     = running_q;
        done_d        = done_q;
        pass_d        = pass_q;
        cause_d       = cause_q;
        exit_code_d   = exit_code_q;
        cycle_count_d = cycle_count_q;
        tohost_s      = 1'b0;
        ecall_s       = 1'b0;
        same_pc_s     = 1'b0;
        halt_s        = 1'b0;
        timeout_s     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d       = S_RESET;
                    rcnt_d        = {RW{1'b0}};
                    stall_d       = {SW{1'b0}};
                    core_res_n_d  = 1'b0;
                    running_d     = 1'b0;
                    done_d        = 1'b0;
                    pass_d        = 1'b0;
                    cause_d       = 2'd0;
                    exit_code_d   = 31'd0;
                    cycle_count_d = {CNT_WIDTH{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            S_RESET: begin
                if (rcnt_q == RES_LAST) begin
                    state_d      = S_RUN;
                    core_res_n_d = 1'b1;
                    running_d    = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RES_ONE;
                end
            end
            S_RUN: begin
                tohost_s  = bus.dmem_wr && (bus.dmem_addr == TOHOST_A) && bus.dmem_wr_data[0];
                ecall_s   = (bus.instr == ECALL_INSN);
                // A zero stall counter marks the first RUN cycle, which has no valid last_pc.
                same_pc_s = (stall_q != {SW{1'b0}}) && (bus.pc == last_pc_q);
                halt_s    = same_pc_s && (stall_q == STALL_LAST);
                timeout_s = (MAX_CYCLES != 0) && (cycle_count_q == TIMEOUT_AT);

                last_pc_d     = bus.pc;
                stall_d       = same_pc_s ? (stall_q + STALL_ONE) : STALL_ONE;
                cycle_count_d = (cycle_count_q == CNT_SAT) ? cycle_count_q
                                                           : (cycle_count_q + CNT_ONE);

                if (tohost_s) begin
                    cause_d     = 2'd0;
                    exit_code_d = bus.dmem_wr_data[31:1];
                    pass_d      = (bus.dmem_wr_data[31:1] == 31'd0);
                end else if (ecall_s) begin
                    cause_d = 2'd1;
                    pass_d  = 1'b1;
                end else if (halt_s) begin
                    cause_d = 2'd2;
                    pass_d  = 1'b1;
                end else if (timeout_s) begin
                    cause_d = 2'd3;
                    pass_d  = 1'b0;
                end else begin
                    cause_d = cause_q;
                end

                if (tohost_s || ecall_s || halt_s || timeout_s) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    running_d    = 1'b0;
                    core_res_n_d = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d      = S_IDLE;
                core_res_n_d = 1'b0;
                running_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q       <= S_IDLE;
            rcnt_q        <= {RW{1'b0}};
            stall_q       <= {SW{1'b0}};
            last_pc_q     <= {ADDR_WIDTH{1'b0}};
            core_res_n_q  <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            cause_q       <= 2'd0;
            exit_code_q   <= 31'd0;
            cycle_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            stall_q       <= stall_d;
            last_pc_q     <= last_pc_d;
            core_res_n_q  <= core_res_n_d;
            running_q     <= running_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            cause_q       <= cause_d;
            exit_code_q   <= exit_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.core_res_n  = core_res_n_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.cause       = cause_q;
    assign bus.exit_code   = exit_code_q;
    assign bus.cycle_count = cycle_count_q;

endmodule
